// File: rtl/eif_array_scheduler.sv
// ============================================================================
// Module  : eif_array_scheduler
// Purpose : Time-multiplexes one EIF update datapath over N_NEURONS virtual
//           neurons. Optional per-neuron refractory counters: REFRACTORY_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module eif_array_scheduler #(
    parameter int unsigned N_NEURONS    = 8,
    parameter int unsigned IDX_W        = 3,
    parameter logic [7:0]  U_REST       = 8'd50,
    parameter int unsigned REFRAC_STEPS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_start,
    output logic             busy,
    output logic             step_done,
    output logic             overrun,
    input  logic             cur_wr_en,
    input  logic [IDX_W-1:0] cur_wr_addr,
    input  logic [7:0]       cur_wr_data,
    output logic             dp_req,
    output logic [7:0]       dp_state,
    output logic [7:0]       dp_current,
    input  logic             dp_ack,
    input  logic [7:0]       dp_next_state,
    input  logic             dp_spike,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_id,
    input  logic             spike_ready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_EMIT = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W:0]   c_NUM  = (IDX_W + 1)'(N_NEURONS);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_overrun;
    logic [7:0]       r_dp_state;
    logic [7:0]       r_dp_current;
    logic [IDX_W-1:0] r_spike_id;
    logic [7:0]       r_mem [N_NEURONS];
    logic [7:0]       r_cur [N_NEURONS];
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_skip;

    assign w_idx_nxt = r_idx + IDX_W'(1);

`ifdef REFRACTORY_EN
    localparam logic [3:0] c_REFRAC_LOAD = 4'(REFRAC_STEPS);
    logic [3:0] r_refrac [N_NEURONS];
    // A refractory neuron spends its REQ slot idle: no request is raised.
    assign w_skip = (r_refrac[r_idx] != 4'd0);
`else
    assign w_skip = 1'b0;
`endif

    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign step_done   = (r_state == S_DONE);
    assign dp_req      = (r_state == S_REQ) && !w_skip;
    assign dp_state    = r_dp_state;
    assign dp_current  = r_dp_current;
    assign spike_valid = (r_state == S_EMIT);
    assign spike_id    = r_spike_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                r_cur[i] <= 8'd0;
            end
        end else if (cur_wr_en && ({1'b0, cur_wr_addr} < c_NUM)) begin
            r_cur[cur_wr_addr] <= cur_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_dp_state   <= 8'd0;
            r_dp_current <= 8'd0;
            r_spike_id   <= '0;
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                r_mem[i] <= U_REST;
`ifdef REFRACTORY_EN
                r_refrac[i] <= 4'd0;
`endif
            end
        end else begin
            if (step_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (step_start) begin
                        r_dp_state   <= r_mem[0];
                        r_dp_current <= r_cur[0];
                        r_busy       <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_skip) begin
`ifdef REFRACTORY_EN
                        r_refrac[r_idx] <= r_refrac[r_idx] - 4'd1;
`endif
                        r_mem[r_idx] <= U_REST;
                        r_state      <= S_NEXT;
                    end else if (dp_ack) begin
                        if (dp_spike) begin
                            r_mem[r_idx] <= U_REST;
                            r_spike_id   <= r_idx;
`ifdef REFRACTORY_EN
                            r_refrac[r_idx] <= c_REFRAC_LOAD;
`endif
                            r_state      <= S_EMIT;
                        end else begin
                            r_mem[r_idx] <= dp_next_state;
                            r_state      <= S_NEXT;
                        end
                    end
                end
                S_EMIT: begin
                    if (spike_ready) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_idx == c_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx        <= w_idx_nxt;
                        r_dp_state   <= r_mem[w_idx_nxt];
                        r_dp_current <= r_cur[w_idx_nxt];
                        r_state      <= S_REQ;
                    end
                end
                S_DONE: begin
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
